tc_cluster_dispatcher: RTL and testbench
========================================

// Module: tc_cluster_dispatcher
// PURPOSE
// - Parametrised dispatcher for a cluster of NUM_CORES int8 tensor cores sharing one operand bus.
// - Replaces the fixed 4-core one-hot start rotation with idle-aware round-robin dispatch.
// - Adds a valid/ready operand handshake, a FETCH_BEATS-beat fetch per job, and a tagged result output.
// - Sits between the operand-staging logic and the tensor core instances.
// PARAMETERS
// - NUM_CORES   4    number of tensor core lanes; >=2
// - A_W         512  A operand beat width
// - B_W         256  B operand beat width
// - C_W         512  C operand / result width
// - FETCH_BEATS 2    operand beats transferred per job; >=1
// - ID_W        $clog2(NUM_CORES)  core index width, derived
// PORTS
// - clk             in   1              clock
// - rst             in   1              asynchronous reset, active-high
// - op_valid        in   1              operand beat valid
// - op_ready        out  1              operand beat accepted when op_valid&&op_ready
// - a_data_in       in   A_W            A beat
// - b_data_in       in   B_W            B beat
// - c_data_in       in   C_W            C beat
// - core_start      out  NUM_CORES      one-hot start pulse
// - core_fetch_done out  NUM_CORES      one-hot fetch-complete pulse
// - core_idle       in   NUM_CORES      per-core idle status
// - core_fetch      in   NUM_CORES      per-core fetch status
// - core_wb         in   NUM_CORES      per-core write-back status
// - core_a/b/c      out  N*A_W/N*B_W/N*C_W  per-core operand buses; lane i = bits [i*W +: W]
// - core_result     in   NUM_CORES*C_W  per-core results
// - res_valid       out  1              registered result valid
// - res_core        out  ID_W           index of the core that produced res_data
// - res_data        out  C_W            registered result
// BEHAVIOUR
// - Reset values:
//   - All outputs 0.
//   - FSM = IDLE, rr_ptr = 0, beat_cnt = 0.
// - FSM:
//   - IDLE:
//     - sel = first i with core_idle[i], searching cyclically from rr_ptr.
//     - If a core is idle: latch sel; next cycle core_start[sel]=1 for exactly 1 cycle -> WAIT.
//     - If no core is idle: stay in IDLE.
//   - WAIT:
//     - Hold until core_fetch[sel]=1, then -> FETCH.
//   - FETCH:
//     - op_ready = core_fetch[sel]; all other states force op_ready = 0.
//     - Lane sel operand buses pass a/b/c_data_in combinationally; other lanes are 0.
//     - Each accepted beat increments beat_cnt.
//     - On the FETCH_BEATS-th accepted beat -> DONE.
//   - DONE:
//     - core_fetch_done[sel]=1 for 1 cycle.
//     - beat_cnt = 0; rr_ptr = (sel+1) mod NUM_CORES; -> IDLE.
// - Round-robin fairness: the core just dispatched is the lowest priority on the next search.
//   - rr_ptr wraps NUM_CORES-1 -> 0.
// - Minimum job overhead (start to fetch_done): 3 + FETCH_BEATS cycles, provided core_fetch rises 1 cycle after start.
// - op_valid low during FETCH: stall and hold beat_cnt; there is no timeout.
// - Result path:
//   - Every cycle, pick the lowest index i with core_wb[i].
//   - Register res_data <= core_result[i], res_core <= i, res_valid <= 1.
//   - If no core_wb is set: res_valid <= 0 and res_data holds.
//   - Latency is 1 cycle. Multiple simultaneous core_wb resolve by lowest index; higher-index results are not captured that cycle.
// - Mid-job core_fetch[sel] drop: op_ready=0 and beat_cnt holds until it rises again.
// - rst asserted mid-job: immediate return to reset values. No start/fetch_done pulse is emitted on the reset edge.
// - Simultaneous op_valid&&op_ready on the last beat while another core is idle: DONE still takes 1 cycle. The next start is issued from IDLE afterwards, with no overlap.
// CONFIGURATION
// - TC_DISPATCH_PERF_EN defined: adds outputs perf_jobs[31:0] and perf_stall[31:0].
//   - perf_jobs increments once per DONE.
//   - perf_stall increments each FETCH cycle with op_valid=0 or core_fetch[sel]=0.
//   - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
// - TC_DISPATCH_PERF_EN undefined: these ports and counters are absent. All other behaviour is identical.
// TESTING
// - Reset, all cores idle, op_valid=1 continuously, core_fetch 1 cycle after start:
//   -> starts to cores 0,1,2,3,0 in order; each job accepts exactly 2 beats; fetch_done one-hot per job.
// - core_idle=4'b1010, rr_ptr=0 -> first start to core 1, next start to core 3. Cores 0 and 2 are never started.
// - op_valid toggled 1,0,0,1 during FETCH -> 2 beats accepted; fetch_done delayed 2 cycles; perf_stall=2 when TC_DISPATCH_PERF_EN is defined.
// - core_wb=4'b0110 with core_result lanes 1=0xAA.., 2=0xBB.. -> next cycle res_valid=1, res_core=1, res_data=0xAA..
// - rst pulsed during FETCH after 1 beat -> op_ready=0, all pulses 0, rr_ptr=0; next dispatch targets core 0.
// - No core idle for 10 cycles -> op_ready=0 and core_start=0 throughout; core 2 becomes idle -> core_start=4'b0100 within 1 cycle.

Source files
------------

// File: rtl/tc_cluster_dispatcher.sv
// Idle-aware round-robin job dispatcher for a tensor core cluster with a shared operand bus.
// Optional perf counters (perf_jobs, perf_stall) are built when TC_DISPATCH_PERF_EN is defined.
module tc_cluster_dispatcher #(
  parameter int NUM_CORES   = 4,
  parameter int A_W         = 512,
  parameter int B_W         = 256,
  parameter int C_W         = 512,
  parameter int FETCH_BEATS = 2,
  parameter int ID_W        = $clog2(NUM_CORES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [A_W-1:0]           a_data_in,
  input  logic [B_W-1:0]           b_data_in,
  input  logic [C_W-1:0]           c_data_in,
  output logic [NUM_CORES-1:0]     core_start,
  output logic [NUM_CORES-1:0]     core_fetch_done,
  input  logic [NUM_CORES-1:0]     core_idle,
  input  logic [NUM_CORES-1:0]     core_fetch,
  input  logic [NUM_CORES-1:0]     core_wb,
  output logic [NUM_CORES*A_W-1:0] core_a,
  output logic [NUM_CORES*B_W-1:0] core_b,
  output logic [NUM_CORES*C_W-1:0] core_c,
  input  logic [NUM_CORES*C_W-1:0] core_result,
  output logic                     res_valid,
  output logic [ID_W-1:0]          res_core,
  output logic [C_W-1:0]           res_data
`ifdef TC_DISPATCH_PERF_EN
  ,
  output logic [31:0]              perf_jobs,
  output logic [31:0]              perf_stall
`endif
);
  localparam int CNT_W = $clog2(FETCH_BEATS + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_FETCH, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  sel_q, sel_d, rr_q, rr_d, pick;
  logic             pick_vld;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [ID_W-1:0]  wb_idx;
  logic             wb_any;

  // Cyclic search from rr_q; descending loop so the nearest idle core wins.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = rr_q;
    pick_vld = 1'b0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (core_idle[idx]) begin
        pick     = ID_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    sel_d           = sel_q;
    rr_d            = rr_q;
    beat_d          = beat_q;
    op_ready        = 1'b0;
    core_start      = '0;
    core_fetch_done = '0;
    unique case (state_q)
      S_IDLE: if (pick_vld) begin
        sel_d   = pick;
        state_d = S_START;
      end
      S_START: begin
        core_start[sel_q] = 1'b1;
        state_d           = S_WAIT;
      end
      S_WAIT: if (core_fetch[sel_q]) state_d = S_FETCH;
      S_FETCH: begin
        op_ready = core_fetch[sel_q];
        if (op_valid && op_ready) begin
          beat_d = beat_q + CNT_W'(1);
          if (beat_q == CNT_W'(FETCH_BEATS - 1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        core_fetch_done[sel_q] = 1'b1;
        beat_d                 = '0;
        rr_d    = (sel_q == ID_W'(NUM_CORES - 1)) ? '0 : sel_q + ID_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
    end
  end

  // Only the selected lane sees the operand bus, and only while fetching.
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_lane
    logic hit;
    assign hit = (state_q == S_FETCH) && (sel_q == ID_W'(g));
    assign core_a[g*A_W +: A_W] = hit ? a_data_in : '0;
    assign core_b[g*B_W +: B_W] = hit ? b_data_in : '0;
    assign core_c[g*C_W +: C_W] = hit ? c_data_in : '0;
  end

  always_comb begin
    wb_idx = '0;
    wb_any = 1'b0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_wb[i]) begin
        wb_idx = ID_W'(i);
        wb_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_core  <= '0;
      res_data  <= '0;
    end else begin
      res_valid <= wb_any;
      if (wb_any) begin
        res_core <= wb_idx;
        res_data <= core_result[int'(wb_idx)*C_W +: C_W];
      end
    end
  end

`ifdef TC_DISPATCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_jobs  <= '0;
      perf_stall <= '0;
    end else begin
      if (state_q == S_DONE && perf_jobs != 32'hFFFF_FFFF)
        perf_jobs <= perf_jobs + 32'd1;
      if (state_q == S_FETCH && (!op_valid || !core_fetch[sel_q]) &&
          perf_stall != 32'hFFFF_FFFF)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tc_cluster_dispatcher.sv
// Randomized bench for tc_cluster_dispatcher: a core-side responder plus a round-robin/result reference model.
module tb_tc_cluster_dispatcher;
  localparam int N  = 4;
  localparam int AW = 512;
  localparam int BW = 256;
  localparam int CW = 512;
  localparam int FB = 2;
  localparam int IW = $clog2(N);

  logic            clk = 0;
  logic            rst = 0;
  logic            op_valid = 0;
  logic            op_ready;
  logic [AW-1:0]   a_data_in = '0;
  logic [BW-1:0]   b_data_in = '0;
  logic [CW-1:0]   c_data_in = '0;
  logic [N-1:0]    core_start, core_fetch_done;
  logic [N-1:0]    core_idle = '0, core_fetch = '0, core_wb = '0;
  logic [N*AW-1:0] core_a;
  logic [N*BW-1:0] core_b;
  logic [N*CW-1:0] core_c;
  logic [N*CW-1:0] core_result = '0;
  logic            res_valid;
  logic [IW-1:0]   res_core;
  logic [CW-1:0]   res_data;
`ifdef TC_DISPATCH_PERF_EN
  logic [31:0]     perf_jobs, perf_stall;
`endif

  int checks = 0;
  int fails  = 0;
  int exp_rr = 0;

  tc_cluster_dispatcher #(.NUM_CORES(N), .A_W(AW), .B_W(BW), .C_W(CW), .FETCH_BEATS(FB)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .a_data_in(a_data_in), .b_data_in(b_data_in), .c_data_in(c_data_in),
    .core_start(core_start), .core_fetch_done(core_fetch_done),
    .core_idle(core_idle), .core_fetch(core_fetch), .core_wb(core_wb),
    .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_result(core_result),
    .res_valid(res_valid), .res_core(res_core), .res_data(res_data)
`ifdef TC_DISPATCH_PERF_EN
    , .perf_jobs(perf_jobs), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // First idle core found walking cyclically from rr.
  function automatic int exp_pick(input logic [N-1:0] idle, input int rr);
    for (int k = 0; k < N; k++) if (idle[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  // Core-side responder for one job: waits for a start, raises fetch on that core,
  // drives op_valid/core_fetch per cycle from the patterns (bit 0 = cycle after start)
  // and records what the dispatcher did. Called and returns at posedge+1.
  task automatic run_job(input logic [N-1:0] idle, input logic [15:0] vpat,
                         input logic [15:0] fpat, output int core, output int swait,
                         output int beats, output int lat, output bit ok_oh,
                         output bit ok_data, output int extra, output bit tmo);
    logic [N*AW-1:0] ea;
    logic [N*BW-1:0] eb;
    logic [N*CW-1:0] ec;
    logic [N-1:0]    oh;
    bit              done;
    core = -1; swait = 0; beats = 0; lat = 0; ok_oh = 1; ok_data = 1;
    extra = 0; tmo = 0; done = 0;
    core_idle = idle; core_fetch = '0; op_valid = 0;
    while (core < 0 && swait < 50) begin
      @(negedge clk);
      swait++;
      if (core_start != '0) begin
        if (!$onehot(core_start)) ok_oh = 0;
        for (int i = N - 1; i >= 0; i--) if (core_start[i]) core = i;
      end
      @(posedge clk); #1;
    end
    if (core < 0) begin
      tmo = 1;
      return;
    end
    oh = '0; oh[core] = 1'b1;
    core_idle[core] = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      op_valid   = (k < 16) ? vpat[k] : 1'b1;
      core_fetch = (k < 16 && !fpat[k]) ? '0 : oh;
      a_data_in  = rnd512();
      b_data_in  = BW'(rnd512());
      c_data_in  = rnd512();
      @(negedge clk);
      lat++;
      if (core_start != '0) extra++;
      if (op_valid && op_ready) begin
        beats++;
        ea = '0; ea[core*AW +: AW] = a_data_in;
        eb = '0; eb[core*BW +: BW] = b_data_in;
        ec = '0; ec[core*CW +: CW] = c_data_in;
        if (core_a !== ea || core_b !== eb || core_c !== ec) ok_data = 0;
      end
      if (core_fetch_done != '0) begin
        if (core_fetch_done !== oh) ok_oh = 0;
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) tmo = 1;
    core_fetch = '0; op_valid = 0; core_idle = idle;
  endtask

  task automatic test_reset();
    rst = 1; core_idle = '0; core_fetch = '0; core_wb = '0; op_valid = 0;
    @(posedge clk); #1;
    checks++;
    if (op_ready !== 0 || core_start !== '0 || core_fetch_done !== '0 ||
        res_valid !== 0 || res_core !== '0 || res_data !== '0 || core_a !== '0) begin
      fails++;
      $display("FAIL reset_outputs: rdy=%b start=%b fd=%b rv=%b rc=%0d want all 0",
               op_ready, core_start, core_fetch_done, res_valid, res_core);
    end
    rst = 0; exp_rr = 0;
    @(posedge clk); #1;
  endtask

  // One job with full per-job checking against the round-robin model.
  task automatic test_dispatch_job(input string nm, input logic [N-1:0] idle);
    int c, sw, bt, lt, ex; bit oh, od, to; int want;
    want = exp_pick(idle, exp_rr);
    run_job(idle, 16'hFFFF, 16'hFFFF, c, sw, bt, lt, oh, od, ex, to);
    checks++;
    if (to || c !== want) begin
      fails++; $display("FAIL %s_core: got %0d (timeout=%0d) want %0d", nm, c, to, want);
    end
    checks++;
    if (bt !== FB || ex !== 0) begin
      fails++; $display("FAIL %s_beats: got %0d extra_starts=%0d want %0d", nm, bt, ex, FB);
    end
    checks++;
    if (!oh || !od) begin
      fails++; $display("FAIL %s_lanes: onehot_ok=%0d data_ok=%0d want 1 1", nm, oh, od);
    end
    if (want >= 0) exp_rr = (want + 1) % N;
  endtask

  task automatic test_round_robin();
    for (int j = 0; j < 5; j++) test_dispatch_job("rr_all_idle", '1);
  endtask

  task automatic test_sparse_idle();
    test_reset();
    for (int j = 0; j < 3; j++) test_dispatch_job("sparse_1010", 4'b1010);
  endtask

  task automatic test_random_dispatch();
    logic [N-1:0] m;
    for (int j = 0; j < 15; j++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      test_dispatch_job("rand_idle", m);
    end
  endtask

  task automatic test_stall();
    int c, sw, bt, lt0, lt1, lt2, ex; bit oh, od, to;
`ifdef TC_DISPATCH_PERF_EN
    logic [31:0] ps0;
`endif
    run_job('1, 16'hFFFF, 16'hFFFF, c, sw, bt, lt0, oh, od, ex, to);
    exp_rr = (c + 1) % N;
    // fetch_done lands 3+FETCH_BEATS cycles after start counted inclusively
    checks++;
    if (to || lt0 !== FB + 2) begin
      fails++; $display("FAIL base_latency: got %0d want %0d", lt0, FB + 2);
    end
`ifdef TC_DISPATCH_PERF_EN
    ps0 = perf_stall;
`endif
    run_job('1, 16'b1111_1111_1111_0011, 16'hFFFF, c, sw, bt, lt1, oh, od, ex, to);
    exp_rr = (c + 1) % N;
    checks++;
    if (to || bt !== FB || lt1 - lt0 !== 2) begin
      fails++; $display("FAIL valid_stall: beats=%0d delay=%0d want %0d 2", bt, lt1 - lt0, FB);
    end
`ifdef TC_DISPATCH_PERF_EN
    checks++;
    if (perf_stall - ps0 !== 32'd2) begin
      fails++; $display("FAIL perf_stall: got %0d want 2", perf_stall - ps0);
    end
`endif
    run_job('1, 16'hFFFF, 16'hFFFB, c, sw, bt, lt2, oh, od, ex, to);
    exp_rr = (c + 1) % N;
    checks++;
    if (to || bt !== FB || lt2 - lt0 !== 1 || !od) begin
      fails++; $display("FAIL fetch_drop: beats=%0d delay=%0d data_ok=%0d want %0d 1 1",
                        bt, lt2 - lt0, od, FB);
    end
  endtask

  task automatic test_no_idle();
    int c, sw, bt, lt, ex, bad; bit oh, od, to;
    core_idle = '0; bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (op_ready !== 0 || core_start !== '0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad !== 0) begin
      fails++; $display("FAIL no_idle_quiet: active cycles=%0d want 0", bad);
    end
    run_job(4'b0100, 16'hFFFF, 16'hFFFF, c, sw, bt, lt, oh, od, ex, to);
    exp_rr = 3;
    checks++;
    if (to || c !== 2 || sw > 2) begin
      fails++; $display("FAIL late_idle_start: core=%0d wait=%0d want core 2 wait<=2", c, sw);
    end
  endtask

  task automatic test_reset_mid_job();
    int c, sw, bt, lt, ex, n; bit oh, od, to, got;
    test_reset();
    test_dispatch_job("pre_abort", '1);
    core_idle = '1; n = 0;
    while (core_start === '0 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (core_start !== 4'b0010) begin
      fails++; $display("FAIL abort_start: got %b want 0010", core_start);
    end
    @(posedge clk); #1;
    core_fetch = 4'b0010; op_valid = 1; got = 0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      got = op_ready && op_valid;
      @(posedge clk); #1; n++;
    end
    rst = 1; #1;
    checks++;
    if (!got || op_ready !== 0 || core_start !== '0 || core_fetch_done !== '0 || core_a !== '0) begin
      fails++; $display("FAIL reset_mid_job: beat_seen=%0d rdy=%b start=%b fd=%b want 1 0 0 0",
                        got, op_ready, core_start, core_fetch_done);
    end
    @(posedge clk); #1;
    rst = 0; core_fetch = '0; op_valid = 0; exp_rr = 0;
    run_job('1, 16'hFFFF, 16'hFFFF, c, sw, bt, lt, oh, od, ex, to);
    checks++;
    if (to || c !== 0 || bt !== FB) begin
      fails++; $display("FAIL post_reset_dispatch: core=%0d beats=%0d want 0 %0d", c, bt, FB);
    end
    exp_rr = 1;
  endtask

  task automatic test_result();
    logic [CW-1:0] exp_d, lane;
    int            exp_i;
    bit            exp_v;
    core_wb = 4'b0110;
    for (int i = 0; i < N; i++) core_result[i*CW +: CW] = rnd512();
    core_result[1*CW +: CW] = {(CW/8){8'hAA}};
    core_result[2*CW +: CW] = {(CW/8){8'hBB}};
    @(posedge clk); #1;
    exp_d = {(CW/8){8'hAA}};
    checks++;
    if (res_valid !== 1 || res_core !== 1 || res_data !== exp_d) begin
      fails++; $display("FAIL result_0110: v=%b core=%0d data=%h want 1 1 aa..", res_valid,
                        res_core, res_data[31:0]);
    end
    exp_i = 1;
    for (int j = 0; j < 25; j++) begin
      core_wb = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      for (int i = 0; i < N; i++) core_result[i*CW +: CW] = rnd512();
      exp_v = 0;
      for (int i = 0; i < N && !exp_v; i++) begin
        if (core_wb[i]) begin
          exp_v = 1; exp_i = i;
          lane = core_result[i*CW +: CW];
          exp_d = lane;
        end
      end
      @(posedge clk); #1;
      checks++;
      if (res_valid !== exp_v || (exp_v && res_core !== IW'(exp_i)) || res_data !== exp_d) begin
        fails++; $display("FAIL result_rand: wb=%b v=%b core=%0d want v=%b core=%0d data_ok=%0d",
                          core_wb, res_valid, res_core, exp_v, exp_i, res_data === exp_d);
      end
    end
    core_wb = '0;
  endtask

  initial begin
    #2;
    test_reset();
    test_round_robin();
    test_sparse_idle();
    test_random_dispatch();
    test_stall();
    test_no_idle();
    test_reset_mid_job();
    test_result();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails + 1);
    $fatal(1);
  end
endmodule
